flit_input_buffer: RTL and testbench

//  Per-port input FIFO of the router. It sits directly upstream of the two-input golden-flit arbiter.
//  - Accepts 32-bit flits from the link with a valid/ready handshake.
//  - Presents the head flit and its golden flag to one arbiter input.
//  - Pops the head when the arbiter grants this port.
//  - Returns one credit per freed slot to the upstream sender, and flags protocol violations.

---
 rtl/router_pkg.sv | 19 +
 rtl/flit_input_buffer.sv | 82 ++++++++
 tb/tb_flit_input_buffer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, field offsets and the flit type.
package router_pkg;

  localparam int unsigned FLIT_WIDTH = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  // Flit field offsets
  localparam int unsigned GOLD_POS   = 0;
  localparam int unsigned SEQ_LSB    = 1;
  localparam int unsigned SEQ_W      = 7;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  // Extract the golden flag from a flit
  function automatic logic flit_is_golden(input flit_t f);
    return f[GOLD_POS];
  endfunction

endpackage

// File: rtl/flit_input_buffer.sv
// Per-port input FIFO feeding one input of the golden-flit arbiter.
// Returns one credit per popped slot and flags overflow/underflow stickily.
module flit_input_buffer
  import router_pkg::*;
#(
  parameter int unsigned FLIT_W   = FLIT_WIDTH,
  parameter int unsigned DEPTH    = FIFO_DEPTH,
  parameter int unsigned GOLD_BIT = GOLD_POS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_W-1:0]          in_flit,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FLIT_W-1:0]          head_flit,
  output logic                       head_valid,
  output logic                       head_golden,
  input  logic                       head_pop,
  output logic                       credit_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_ovf,
  output logic                       err_udf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  // Status and head outputs come only from registered count/pointers/storage
  always_comb begin
    in_ready    = (count < CNT_W'(DEPTH));
    head_valid  = (count != '0);
    head_flit   = mem[rd_ptr];
    head_golden = head_valid & head_flit[GOLD_BIT];
    push        = in_valid & in_ready;
    pop         = head_pop & head_valid;
  end

  // Storage write; not reset, contents are qualified by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  // Pointers, occupancy, credit pulse and sticky protocol errors
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      credit_out <= 1'b0;
      err_ovf    <= 1'b0;
      err_udf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      credit_out <= pop;
      if (in_valid && !in_ready) begin
        err_ovf <= 1'b1;
      end
      if (head_pop && !head_valid) begin
        err_udf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flit_input_buffer.sv
// Directed self-checking bench for flit_input_buffer (DEPTH=4).
module tb_flit_input_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] head_flit;
  logic        head_valid;
  logic        head_golden;
  logic        head_pop;
  logic        credit_out;
  logic [2:0]  count;
  logic        err_ovf;
  logic        err_udf;

  int unsigned total = 0;
  int unsigned bad   = 0;

  flit_input_buffer #(.FLIT_W(32), .DEPTH(4), .GOLD_BIT(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit     (in_flit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .head_flit   (head_flit),
    .head_valid  (head_valid),
    .head_golden (head_golden),
    .head_pop    (head_pop),
    .credit_out  (credit_out),
    .count       (count),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fill [4];
  logic [31:0] q [$];
  logic [31:0] v;

  initial begin
    fill[0] = 32'h000800c2; fill[1] = 32'h111880c6;
    fill[2] = 32'h000880c2; fill[3] = 32'h111800c7;
    rst = 1'b1; in_flit = '0; in_valid = 1'b0; head_pop = 1'b0;
    step();
    rst = 1'b0;
    step();

    // 1: reset/idle
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_head_valid", 32'(head_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_credit", 32'(credit_out), 32'd0);
    check("rst_ovf", 32'(err_ovf), 32'd0);
    check("rst_udf", 32'(err_udf), 32'd0);

    // 2: single golden flit through
    in_flit = 32'h000800c3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t2_head", head_flit, 32'h000800c3);
    check("t2_valid", 32'(head_valid), 32'd1);
    check("t2_golden", 32'(head_golden), 32'd1);
    check("t2_count", 32'(count), 32'd1);
    check("t2_credit_pre", 32'(credit_out), 32'd0);
    head_pop = 1'b1;
    step();
    head_pop = 1'b0;
    check("t2_valid_after", 32'(head_valid), 32'd0);
    check("t2_golden_after", 32'(head_golden), 32'd0);
    check("t2_credit", 32'(credit_out), 32'd1);
    step();
    check("t2_credit_end", 32'(credit_out), 32'd0);

    // 3: fill to full, overflow, drain in order
    for (int i = 0; i < 4; i++) begin
      in_flit = fill[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("t3_count_full", 32'(count), 32'd4);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    in_flit = 32'hdeadbeef; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t3_ovf", 32'(err_ovf), 32'd1);
    check("t3_count_after_ovf", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t3_head", head_flit, fill[i]);
      check("t3_golden", 32'(head_golden), (i == 3) ? 32'd1 : 32'd0);
      head_pop = 1'b1;
      step();
      check("t3_credit", 32'(credit_out), 32'd1);
    end
    head_pop = 1'b0;
    check("t3_count_empty", 32'(count), 32'd0);
    check("t3_udf_clear", 32'(err_udf), 32'd0);
    step();
    check("t3_credit_end", 32'(credit_out), 32'd0);
    check("t3_ovf_sticky", 32'(err_ovf), 32'd1);

    // 4: steady push+pop at count=2, pointers wrap
    q.delete();
    for (int i = 0; i < 2; i++) begin
      v = 32'ha0000000 + 32'(i);
      in_flit = v; in_valid = 1'b1; q.push_back(v);
      step();
    end
    check("t4_count_pre", 32'(count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      v = 32'hb0000010 + 32'(i * 3);
      in_flit = v; in_valid = 1'b1; head_pop = 1'b1;
      check("t4_head", head_flit, q.pop_front());
      q.push_back(v);
      step();
      check("t4_count", 32'(count), 32'd2);
      check("t4_credit", 32'(credit_out), 32'd1);
    end
    in_valid = 1'b0; head_pop = 1'b0;
    step();
    check("t4_credit_end", 32'(credit_out), 32'd0);
    for (int i = 0; i < 2; i++) begin
      check("t4_drain", head_flit, q.pop_front());
      head_pop = 1'b1;
      step();
    end
    head_pop = 1'b0;
    step();
    check("t4_empty", 32'(head_valid), 32'd0);

    // 5: underflow
    head_pop = 1'b1;
    step();
    head_pop = 1'b0;
    check("t5_udf", 32'(err_udf), 32'd1);
    check("t5_credit", 32'(credit_out), 32'd0);
    check("t5_count", 32'(count), 32'd0);
    check("t5_valid", 32'(head_valid), 32'd0);

    // 6: reset mid-traffic (pop asserted during reset must not credit)
    for (int i = 0; i < 3; i++) begin
      in_flit = fill[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("t6_count_pre", 32'(count), 32'd3);
    rst = 1'b1; head_pop = 1'b1;
    step();
    rst = 1'b0; head_pop = 1'b0;
    check("t6_count", 32'(count), 32'd0);
    check("t6_valid", 32'(head_valid), 32'd0);
    check("t6_ovf", 32'(err_ovf), 32'd0);
    check("t6_udf", 32'(err_udf), 32'd0);
    check("t6_credit", 32'(credit_out), 32'd0);
    in_flit = 32'h111880c7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t6_credit_post", 32'(credit_out), 32'd0);
    check("t6_head", head_flit, 32'h111880c7);
    check("t6_head_valid", 32'(head_valid), 32'd1);
    check("t6_golden", 32'(head_golden), 32'd1);
    check("t6_count_post", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
